// File: rtl/axil_led_pkg.sv
// Shared definitions for the AXI4-Lite LED controller: register offsets, response codes, FSM states.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package axil_led_pkg;

    // Byte offsets of the register map; address bits [1:0] are ignored on decode.
    localparam logic [7:0] REG_DATA     = 8'h00;
    localparam logic [7:0] REG_MODE     = 8'h04;
    localparam logic [7:0] REG_DUTY     = 8'h08;
    localparam logic [7:0] REG_PRESCALE = 8'h0C;
    localparam logic [7:0] REG_INFO     = 8'h10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {W_IDLE, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;

    // Merge a 32-bit write into an existing value, one byte lane per strobe bit.
    function automatic logic [31:0] apply_strb(input logic [31:0] old,
                                               input logic [31:0] wdata,
                                               input logic [3:0]  strb);
        logic [31:0] res;
        res = old;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) res[b*8 +: 8] = wdata[b*8 +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/led_pwm_gen.sv
// PWM source: prescaler tick drives a free-running PWM counter, compared against DUTY.
// Latency: pwm_on is combinational from the registered counter; a DUTY change is seen immediately.
// Backpressure: none. Ports: clk, rst (sync, high), prescale, duty, presc_clear in; pwm_on out.
module led_pwm_gen
    import axil_led_pkg::*;
#(
    parameter int PWM_W      = 8,
    parameter int PRESCALE_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic [PWM_W-1:0]      duty,
    input  logic                  presc_clear,
    output logic                  pwm_on
);

    logic [PRESCALE_W-1:0] presc_cnt;
    logic [PWM_W-1:0]      pwm_cnt;

    // The >= compare makes a PRESCALE write below the current count wrap at once
    // instead of running all the way round the counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            presc_cnt <= '0;
            pwm_cnt   <= '0;
        end else if (presc_clear) begin
            presc_cnt <= '0;
        end else if (presc_cnt >= prescale) begin
            presc_cnt <= '0;
            pwm_cnt   <= pwm_cnt + PWM_W'(1);
        end else begin
            presc_cnt <= presc_cnt + PRESCALE_W'(1);
        end
    end

    assign pwm_on = (pwm_cnt < duty);

endmodule

// File: rtl/axil_led_ctrl.sv
// AXI4-Lite slave driving NUM_LEDS outputs, each static or PWM-dimmed; registers read back.
// Latency: write commits the cycle after AW+W are held, bvalid/led_o next cycle; read data one cycle after AR.
// Backpressure: one outstanding write and one read; ready drops while busy, returns on B/R handshake.
module axil_led_ctrl
    import axil_led_pkg::*;
#(
    parameter int NUM_LEDS   = 8,
    parameter int PWM_W      = 8,
    parameter int PRESCALE_W = 16,
    parameter int ADDR_W     = 8
) (
    input  logic                ACLK,
    input  logic                ARESET,
    input  logic [ADDR_W-1:0]   s_axi_awaddr,
    input  logic                s_axi_awvalid,
    output logic                s_axi_awready,
    input  logic [31:0]         s_axi_wdata,
    input  logic [3:0]          s_axi_wstrb,
    input  logic                s_axi_wvalid,
    output logic                s_axi_wready,
    output logic [1:0]          s_axi_bresp,
    output logic                s_axi_bvalid,
    input  logic                s_axi_bready,
    input  logic [ADDR_W-1:0]   s_axi_araddr,
    input  logic                s_axi_arvalid,
    output logic                s_axi_arready,
    output logic [31:0]         s_axi_rdata,
    output logic [1:0]          s_axi_rresp,
    output logic                s_axi_rvalid,
    input  logic                s_axi_rready,
    output logic [NUM_LEDS-1:0] led_o
);

    w_state_t w_state, w_state_nxt;
    r_state_t r_state, r_state_nxt;

    logic                  aw_held, w_held;
    logic [ADDR_W-1:0]     aw_addr_q;
    logic [31:0]           wdata_q;
    logic [3:0]            wstrb_q;
    logic [1:0]            bresp_q, rresp_q;
    logic [31:0]           rdata_q;

    logic [NUM_LEDS-1:0]   data_q, mode_q, data_nxt, mode_nxt, led_q;
    logic [PWM_W-1:0]      duty_q, duty_nxt;
    logic [PRESCALE_W-1:0] prescale_q, prescale_nxt;

    logic                  commit, b_done, wr_err, presc_clear, pwm_on;
    logic [31:0]           rd_val;
    logic                  rd_err;

    // Word-aligned decode; the low two address bits are masked off.
    function automatic logic hit(input logic [ADDR_W-1:0] a, input logic [7:0] off);
        return (a & ~ADDR_W'(3)) == ADDR_W'(off);
    endfunction

    // ---------------- write channel ----------------
    assign s_axi_awready = ~aw_held;
    assign s_axi_wready  = ~w_held;
    assign s_axi_bvalid  = (w_state == W_RESP);
    assign s_axi_bresp   = bresp_q;
    assign commit        = (w_state == W_IDLE) && aw_held && w_held;
    assign b_done        = (w_state == W_RESP) && s_axi_bready;

    always_comb begin
        w_state_nxt = w_state;
        case (w_state)
            W_IDLE:  if (aw_held && w_held) w_state_nxt = W_RESP;
            W_RESP:  if (s_axi_bready)      w_state_nxt = W_IDLE;
            default: w_state_nxt = W_IDLE;
        endcase
    end

    // Register update happens only in the commit cycle; an error leaves every register alone.
    always_comb begin
        data_nxt     = data_q;
        mode_nxt     = mode_q;
        duty_nxt     = duty_q;
        prescale_nxt = prescale_q;
        wr_err       = 1'b0;
        presc_clear  = 1'b0;
        if (commit) begin
            if (hit(aw_addr_q, REG_DATA)) begin
                data_nxt = NUM_LEDS'(apply_strb(32'(data_q), wdata_q, wstrb_q));
            end else if (hit(aw_addr_q, REG_MODE)) begin
                mode_nxt = NUM_LEDS'(apply_strb(32'(mode_q), wdata_q, wstrb_q));
            end else if (hit(aw_addr_q, REG_DUTY)) begin
                duty_nxt = PWM_W'(apply_strb(32'(duty_q), wdata_q, wstrb_q));
            end else if (hit(aw_addr_q, REG_PRESCALE)) begin
                prescale_nxt = PRESCALE_W'(apply_strb(32'(prescale_q), wdata_q, wstrb_q));
                presc_clear  = 1'b1;
            end else begin
                wr_err = 1'b1;
            end
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            w_state    <= W_IDLE;
            aw_held    <= 1'b0;
            w_held     <= 1'b0;
            aw_addr_q  <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            bresp_q    <= RESP_OKAY;
            data_q     <= '0;
            mode_q     <= '0;
            duty_q     <= '0;
            prescale_q <= '0;
            led_q      <= '0;
        end else begin
            w_state    <= w_state_nxt;
            data_q     <= data_nxt;
            mode_q     <= mode_nxt;
            duty_q     <= duty_nxt;
            prescale_q <= prescale_nxt;
            if (commit) bresp_q <= wr_err ? RESP_SLVERR : RESP_OKAY;
            if (b_done) begin
                aw_held <= 1'b0;
                w_held  <= 1'b0;
            end else begin
                if (s_axi_awvalid && s_axi_awready) begin
                    aw_held   <= 1'b1;
                    aw_addr_q <= s_axi_awaddr;
                end
                if (s_axi_wvalid && s_axi_wready) begin
                    w_held  <= 1'b1;
                    wdata_q <= s_axi_wdata;
                    wstrb_q <= s_axi_wstrb;
                end
            end
            // Built from the next-state registers so a DATA/MODE commit shows up alongside bvalid.
            led_q <= data_nxt & (~mode_nxt | {NUM_LEDS{pwm_on}});
        end
    end

    assign led_o = led_q;

    // ---------------- read channel ----------------
    assign s_axi_arready = (r_state == R_IDLE);
    assign s_axi_rvalid  = (r_state == R_DATA);
    assign s_axi_rdata   = rdata_q;
    assign s_axi_rresp   = rresp_q;

    always_comb begin
        r_state_nxt = r_state;
        case (r_state)
            R_IDLE:  if (s_axi_arvalid) r_state_nxt = R_DATA;
            R_DATA:  if (s_axi_rready)  r_state_nxt = R_IDLE;
            default: r_state_nxt = R_IDLE;
        endcase
    end

    // Reads sample the current registers, so a same-cycle write commit is not yet visible.
    always_comb begin
        rd_val = '0;
        rd_err = 1'b0;
        if (hit(s_axi_araddr, REG_DATA))          rd_val = 32'(data_q);
        else if (hit(s_axi_araddr, REG_MODE))     rd_val = 32'(mode_q);
        else if (hit(s_axi_araddr, REG_DUTY))     rd_val = 32'(duty_q);
        else if (hit(s_axi_araddr, REG_PRESCALE)) rd_val = 32'(prescale_q);
        else if (hit(s_axi_araddr, REG_INFO))     rd_val = {16'd0, 8'(PWM_W), 8'(NUM_LEDS)};
        else                                      rd_err = 1'b1;
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_state <= R_IDLE;
            rdata_q <= '0;
            rresp_q <= RESP_OKAY;
        end else begin
            r_state <= r_state_nxt;
            if (s_axi_arvalid && s_axi_arready) begin
                rdata_q <= rd_val;
                rresp_q <= rd_err ? RESP_SLVERR : RESP_OKAY;
            end
        end
    end

    led_pwm_gen #(
        .PWM_W      (PWM_W),
        .PRESCALE_W (PRESCALE_W)
    ) u_pwm (
        .clk         (ACLK),
        .rst         (ARESET),
        .prescale    (prescale_q),
        .duty        (duty_q),
        .presc_clear (presc_clear),
        .pwm_on      (pwm_on)
    );

endmodule

// File: tb/tb_axil_led_ctrl.sv
// Bench for axil_led_ctrl: vector table, hand-written corner sequences, random traffic vs a register model.
// Latency: n/a.
// Backpressure: exercised through delayed bready/rready and skewed AW/W.
module tb_axil_led_ctrl;

    localparam int NUM_LEDS   = 8;
    localparam int PWM_W      = 8;
    localparam int PRESCALE_W = 16;
    localparam int ADDR_W     = 8;

    localparam logic [31:0] LED_MASK   = (32'd1 << NUM_LEDS) - 32'd1;
    localparam logic [31:0] DUTY_MASK  = (32'd1 << PWM_W) - 32'd1;
    localparam logic [31:0] PRESC_MASK = (32'd1 << PRESCALE_W) - 32'd1;

    logic                ACLK = 1'b0;
    logic                ARESET;
    logic [ADDR_W-1:0]   s_axi_awaddr;
    logic                s_axi_awvalid;
    logic                s_axi_awready;
    logic [31:0]         s_axi_wdata;
    logic [3:0]          s_axi_wstrb;
    logic                s_axi_wvalid;
    logic                s_axi_wready;
    logic [1:0]          s_axi_bresp;
    logic                s_axi_bvalid;
    logic                s_axi_bready;
    logic [ADDR_W-1:0]   s_axi_araddr;
    logic                s_axi_arvalid;
    logic                s_axi_arready;
    logic [31:0]         s_axi_rdata;
    logic [1:0]          s_axi_rresp;
    logic                s_axi_rvalid;
    logic                s_axi_rready;
    logic [NUM_LEDS-1:0] led_o;

    axil_led_ctrl #(
        .NUM_LEDS(NUM_LEDS), .PWM_W(PWM_W), .PRESCALE_W(PRESCALE_W), .ADDR_W(ADDR_W)
    ) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
        .s_axi_wready(s_axi_wready), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
        .s_axi_bready(s_axi_bready), .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid),
        .s_axi_arready(s_axi_arready), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
        .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready), .led_o(led_o)
    );

    always #5 ACLK = ~ACLK;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] m_data, m_mode, m_duty, m_presc;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] s);
        logic [31:0] mask;
        mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
        return (old & ~mask) | (d & mask);
    endfunction

    task automatic ref_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                             output logic [1:0] resp);
        resp = 2'b00;
        case (a & 8'hFC)
            8'h00:   m_data  = merge(m_data,  d, s) & LED_MASK;
            8'h04:   m_mode  = merge(m_mode,  d, s) & LED_MASK;
            8'h08:   m_duty  = merge(m_duty,  d, s) & DUTY_MASK;
            8'h0C:   m_presc = merge(m_presc, d, s) & PRESC_MASK;
            default: resp = 2'b10;
        endcase
    endtask

    task automatic ref_read(input logic [7:0] a, output logic [31:0] d, output logic [1:0] resp);
        resp = 2'b00;
        case (a & 8'hFC)
            8'h00:   d = m_data;
            8'h04:   d = m_mode;
            8'h08:   d = m_duty;
            8'h0C:   d = m_presc;
            8'h10:   d = (PWM_W << 8) | NUM_LEDS;
            default: begin d = 32'h0; resp = 2'b10; end
        endcase
    endtask

    // ---------------- bus tasks ----------------
    // skew > 0: W leads AW by skew cycles; skew < 0: AW leads W.
    task automatic axi_write(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input int skew, input int bdelay,
                             output logic [1:0] resp, output logic [NUM_LEDS-1:0] led);
        int  cyc, n, aw_start, w_start;
        bit  aw_done, w_done, aw_f, w_f;
        cyc = 0; aw_done = 0; w_done = 0;
        aw_start = (skew > 0) ? skew : 0;
        w_start  = (skew < 0) ? -skew : 0;
        s_axi_awaddr = addr; s_axi_wdata = data; s_axi_wstrb = strb;
        while (!(aw_done && w_done) && cyc < 50) begin
            s_axi_awvalid = !aw_done && (cyc >= aw_start);
            s_axi_wvalid  = !w_done  && (cyc >= w_start);
            aw_f = s_axi_awvalid && s_axi_awready;
            w_f  = s_axi_wvalid  && s_axi_wready;
            @(posedge ACLK); #1;
            if (aw_f) aw_done = 1;
            if (w_f)  w_done  = 1;
            cyc++;
        end
        s_axi_awvalid = 0; s_axi_wvalid = 0;
        if (!(aw_done && w_done)) chk("w_accept_timeout", 0, 1);
        n = 0;
        while (!s_axi_bvalid && n < 20) begin @(posedge ACLK); #1; n++; end
        chk("w_bvalid_latency", n, 1);
        resp = s_axi_bresp;
        led  = led_o;
        for (int i = 0; i < bdelay; i++) begin
            @(posedge ACLK); #1;
            chk("w_hold_bvalid", s_axi_bvalid, 1);
            chk("w_hold_bresp", s_axi_bresp, resp);
            chk("w_hold_no_accept", {s_axi_awready, s_axi_wready}, 0);
        end
        s_axi_bready = 1;
        @(posedge ACLK); #1;
        s_axi_bready = 0;
        chk("w_bvalid_drop", s_axi_bvalid, 0);
        chk("w_ready_back", {s_axi_awready, s_axi_wready}, 2'b11);
    endtask

    task automatic axi_read(input logic [7:0] addr, input int rdelay,
                            output logic [31:0] data, output logic [1:0] resp);
        int n;
        n = 0;
        s_axi_araddr = addr; s_axi_arvalid = 1;
        while (!s_axi_arready && n < 20) begin @(posedge ACLK); #1; n++; end
        @(posedge ACLK); #1;
        s_axi_arvalid = 0;
        chk("r_rvalid_latency", s_axi_rvalid, 1);
        data = s_axi_rdata;
        resp = s_axi_rresp;
        for (int i = 0; i < rdelay; i++) begin
            @(posedge ACLK); #1;
            chk("r_hold_rvalid", s_axi_rvalid, 1);
            chk("r_hold_rdata", s_axi_rdata, data);
            chk("r_hold_rresp", s_axi_rresp, resp);
            chk("r_hold_no_accept", s_axi_arready, 0);
        end
        s_axi_rready = 1;
        @(posedge ACLK); #1;
        s_axi_rready = 0;
        chk("r_rvalid_drop", s_axi_rvalid, 0);
        chk("r_arready_back", s_axi_arready, 1);
    endtask

    // Counts cycles with led_o[3:0] fully on; partial nibbles or a dim upper nibble count as bad.
    task automatic count_on(input int cycles, output int on_cnt, output int bad);
        on_cnt = 0; bad = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge ACLK); #1;
            if (led_o[3:0] == 4'hF) on_cnt++;
            else if (led_o[3:0] != 4'h0) bad++;
            if (led_o[7:4] != 4'hF) bad++;
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        bit          wr;
        logic [7:0]  addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [1:0]  resp;
        logic [31:0] rdata;
        bit          chk_led;
        logic [7:0]  led;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(input bit wr, input logic [7:0] a, input logic [31:0] d,
                                input logic [3:0] s, input logic [1:0] r, input logic [31:0] rd,
                                input bit cl, input logic [7:0] l);
        vec_t v;
        v.wr = wr; v.addr = a; v.data = d; v.strb = s; v.resp = r;
        v.rdata = rd; v.chk_led = cl; v.led = l;
        return v;
    endfunction

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: run still active, required completion");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [1:0]          resp, eresp;
        logic [31:0]         rd, erd;
        logic [NUM_LEDS-1:0] led;
        int                  on_cnt, bad, n;
        logic [7:0]          addrs [7];

        ARESET = 1;
        s_axi_awaddr = '0; s_axi_awvalid = 0; s_axi_wdata = '0; s_axi_wstrb = '0;
        s_axi_wvalid = 0; s_axi_bready = 0; s_axi_araddr = '0; s_axi_arvalid = 0;
        s_axi_rready = 0;
        m_data = 0; m_mode = 0; m_duty = 0; m_presc = 0;
        repeat (3) @(posedge ACLK);
        #1;
        ARESET = 0;
        chk("rst_readies", {s_axi_awready, s_axi_wready, s_axi_arready}, 3'b111);
        chk("rst_valids", {s_axi_bvalid, s_axi_rvalid}, 2'b00);
        chk("rst_resps", {s_axi_bresp, s_axi_rresp}, 4'b0000);
        chk("rst_rdata", s_axi_rdata, 0);
        chk("rst_led", led_o, 0);

        vt.push_back(mk(1, 8'h04, 32'h00000000, 4'hF, 2'b00, 0, 0, 8'h00));
        vt.push_back(mk(1, 8'h00, 32'hFFFFFFFF, 4'hF, 2'b00, 0, 1, 8'hFF));
        vt.push_back(mk(0, 8'h00, 0, 0, 2'b00, 32'h000000FF, 0, 0));
        vt.push_back(mk(1, 8'h00, 32'hDEADBEEF, 4'hF, 2'b00, 0, 1, 8'hEF));
        vt.push_back(mk(0, 8'h00, 0, 0, 2'b00, 32'h000000EF, 0, 0));
        vt.push_back(mk(1, 8'h00, 32'h0000AB00, 4'h2, 2'b00, 0, 1, 8'hEF));
        vt.push_back(mk(0, 8'h00, 0, 0, 2'b00, 32'h000000EF, 0, 0));
        vt.push_back(mk(1, 8'h40, 32'h12345678, 4'hF, 2'b10, 0, 1, 8'hEF));
        vt.push_back(mk(0, 8'h40, 0, 0, 2'b10, 32'h00000000, 0, 0));
        vt.push_back(mk(0, 8'h10, 0, 0, 2'b00, 32'h00000808, 0, 0));
        vt.push_back(mk(1, 8'h10, 32'hFFFFFFFF, 4'hF, 2'b10, 0, 0, 0));
        vt.push_back(mk(0, 8'h10, 0, 0, 2'b00, 32'h00000808, 0, 0));
        vt.push_back(mk(0, 8'h03, 0, 0, 2'b00, 32'h000000EF, 0, 0));
        vt.push_back(mk(1, 8'h08, 32'h00001234, 4'hF, 2'b00, 0, 0, 0));
        vt.push_back(mk(0, 8'h08, 0, 0, 2'b00, 32'h00000034, 0, 0));
        vt.push_back(mk(1, 8'h0C, 32'hABCDEF01, 4'h5, 2'b00, 0, 0, 0));
        vt.push_back(mk(0, 8'h0C, 0, 0, 2'b00, 32'h00000001, 0, 0));
        vt.push_back(mk(1, 8'h0C, 32'h00000000, 4'hF, 2'b00, 0, 0, 0));
        vt.push_back(mk(0, 8'h0C, 0, 0, 2'b00, 32'h00000000, 0, 0));
        vt.push_back(mk(1, 8'h04, 32'hFFFFFF00, 4'hE, 2'b00, 0, 1, 8'hEF));
        vt.push_back(mk(0, 8'h04, 0, 0, 2'b00, 32'h00000000, 0, 0));

        foreach (vt[i]) begin
            if (vt[i].wr) begin
                axi_write(vt[i].addr, vt[i].data, vt[i].strb, 0, 0, resp, led);
                chk($sformatf("vec%0d_bresp", i), resp, vt[i].resp);
                if (vt[i].chk_led) chk($sformatf("vec%0d_led", i), led, vt[i].led);
            end else begin
                axi_read(vt[i].addr, 0, rd, resp);
                chk($sformatf("vec%0d_rdata", i), rd, vt[i].rdata);
                chk($sformatf("vec%0d_rresp", i), resp, vt[i].resp);
            end
        end
        m_data = 32'hEF; m_mode = 0; m_duty = 32'h34; m_presc = 0;

        // W three cycles ahead of AW, bready held off five cycles: exactly one commit.
        axi_write(8'h00, 32'h0000003C, 4'hF, 3, 5, resp, led);
        chk("skew_bresp", resp, 2'b00);
        chk("skew_led", led, 8'h3C);
        axi_read(8'h00, 5, rd, resp);
        chk("skew_rdata", rd, 32'h3C);
        m_data = 32'h3C;

        // Read and write commit to DATA in the same cycle: read sees the old value.
        s_axi_awaddr = 8'h00; s_axi_wdata = 32'h5A; s_axi_wstrb = 4'hF;
        s_axi_awvalid = 1; s_axi_wvalid = 1;
        @(posedge ACLK); #1;
        s_axi_awvalid = 0; s_axi_wvalid = 0;
        s_axi_araddr = 8'h00; s_axi_arvalid = 1;
        @(posedge ACLK); #1;
        s_axi_arvalid = 0;
        chk("rw_same_bvalid", s_axi_bvalid, 1);
        chk("rw_same_rvalid", s_axi_rvalid, 1);
        chk("rw_same_old_rdata", s_axi_rdata, 32'h3C);
        s_axi_bready = 1; s_axi_rready = 1;
        @(posedge ACLK); #1;
        s_axi_bready = 0; s_axi_rready = 0;
        axi_read(8'h00, 0, rd, resp);
        chk("rw_same_new_rdata", rd, 32'h5A);
        m_data = 32'h5A;

        // Random traffic against the register model.
        addrs = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h40};
        for (int t = 0; t < 150; t++) begin
            logic [7:0]  a;
            logic [31:0] d;
            logic [3:0]  s;
            a = addrs[$urandom_range(0, 6)] | 8'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1) begin
                d = $urandom;
                s = 4'($urandom_range(0, 15));
                axi_write(a, d, s, $urandom_range(0, 6) - 3, $urandom_range(0, 3), resp, led);
                ref_write(a, d, s, eresp);
                chk("rnd_bresp", resp, eresp);
                chk("rnd_led_static", led & ~m_mode[7:0], m_data[7:0] & ~m_mode[7:0]);
            end else begin
                axi_read(a, $urandom_range(0, 3), rd, resp);
                ref_read(a, erd, eresp);
                chk("rnd_rdata", rd, erd);
                chk("rnd_rresp", resp, eresp);
            end
        end

        // PWM: lower nibble dimmed, upper nibble static.
        axi_write(8'h0C, 32'h0, 4'hF, 0, 0, resp, led);
        axi_write(8'h00, 32'hFF, 4'hF, 0, 0, resp, led);
        axi_write(8'h04, 32'h0F, 4'hF, 0, 0, resp, led);
        axi_write(8'h08, 32'h40, 4'hF, 0, 0, resp, led);
        count_on(512, on_cnt, bad);
        chk("pwm_duty40_on", on_cnt, 128);
        chk("pwm_duty40_bad", bad, 0);
        axi_write(8'h08, 32'hFF, 4'hF, 0, 0, resp, led);
        count_on(512, on_cnt, bad);
        chk("pwm_dutymax_on", on_cnt, 510);
        chk("pwm_dutymax_bad", bad, 0);
        axi_write(8'h08, 32'h00, 4'hF, 0, 0, resp, led);
        count_on(300, on_cnt, bad);
        chk("pwm_duty0_on", on_cnt, 0);
        chk("pwm_duty0_bad", bad, 0);
        axi_write(8'h08, 32'h40, 4'hF, 0, 0, resp, led);
        axi_write(8'h0C, 32'h3, 4'hF, 0, 0, resp, led);
        count_on(1024, on_cnt, bad);
        chk("pwm_presc3_on", on_cnt, 256);
        chk("pwm_presc3_bad", bad, 0);

        // Reset while a write response is pending and PWM is running.
        s_axi_awaddr = 8'h00; s_axi_wdata = 32'h11; s_axi_wstrb = 4'hF;
        s_axi_awvalid = 1; s_axi_wvalid = 1;
        @(posedge ACLK); #1;
        s_axi_awvalid = 0; s_axi_wvalid = 0;
        n = 0;
        while (!s_axi_bvalid && n < 20) begin @(posedge ACLK); #1; n++; end
        chk("arst_bvalid_pending", s_axi_bvalid, 1);
        ARESET = 1;
        @(posedge ACLK); #1;
        ARESET = 0;
        chk("arst_bvalid", s_axi_bvalid, 0);
        chk("arst_rvalid", s_axi_rvalid, 0);
        chk("arst_led", led_o, 0);
        chk("arst_readies", {s_axi_awready, s_axi_wready, s_axi_arready}, 3'b111);
        chk("arst_bresp", s_axi_bresp, 0);
        m_data = 0; m_mode = 0; m_duty = 0; m_presc = 0;
        for (int r = 0; r < 4; r++) begin
            logic [7:0] a;
            a = 8'(r * 4);
            axi_read(a, 0, rd, resp);
            ref_read(a, erd, eresp);
            chk($sformatf("arst_reg%0d", r), rd, erd);
        end
        chk("arst_led_after", led_o, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
